glitchless_burst_rd: RTL and testbench
======================================

// Module: glitchless_burst_rd
// PURPOSE
//  Parametrised burst read controller with glitch-free control outputs: rd, ds and err are state-register bits, with no decode logic.
//  NCH requesters share one wait-stated read port through a round-robin arbiter; each grant runs a BURST_LEN-beat transaction.
//  A per-beat wait-state timeout aborts a hung transaction with a one-cycle err pulse.
//  Sits between the requester-side go lines and a slow memory/peripheral that drives ws.
// PARAMETERS
//  NCH        4   number of requesters (>=1)
//  BURST_LEN  4   beats per granted transaction (>=1)
//  MAX_WAIT   8   consecutive ws cycles tolerated per beat before abort (>=1)
//  BEAT_W     localparam = max(1,$clog2(BURST_LEN)); WAIT_W = max(1,$clog2(MAX_WAIT))
// PORTS
//  clk      in   1       rising-edge clock
//  reset_n  in   1       synchronous, active-low reset
//  go       in   NCH     per-requester request level, sampled only in IDLE
//  ws       in   1       wait-state from target, sampled only in DLY
//  rd       out  1       read strobe = state bit 2
//  ds       out  1       done strobe = state bit 3, one cycle per completed burst
//  err      out  1       timeout strobe = state bit 4, one cycle per aborted burst
//  gnt      out  NCH     registered one-hot grant, held READ..DONE/ERR inclusive
//  beat     out  BEAT_W  registered index of current beat, 0..BURST_LEN-1
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state=IDLE, rd=ds=err=0, gnt=0, beat=0, wait_cnt=0, rr_ptr=0.
//   Reset overrides everything, including mid-burst; no ds/err is emitted for an aborted burst.
//  Output-encoded state, {err,ds,rd,s1,s0}:
//   IDLE=000_00, READ=001_01, DLY=001_10, DONE=010_11, ERR=100_00.
//  Transitions, one per clock:
//   IDLE: |go=1 -> READ; gnt<=arb pick, beat<=0, wait_cnt<=0. Else stay.
//   READ: -> DLY unconditionally.
//   DLY, ws=0, beat==BURST_LEN-1 -> DONE.
//   DLY, ws=0, otherwise -> READ; beat<=beat+1, wait_cnt<=0.
//   DLY, ws=1, wait_cnt==MAX_WAIT-1 -> ERR.
//   DLY, ws=1, otherwise -> READ (beat re-issued); wait_cnt<=wait_cnt+1.
//   DONE: -> IDLE; gnt<=0; rr_ptr<=granted index+1 mod NCH.
//   ERR: -> IDLE; gnt<=0; rr_ptr<=granted index+1 mod NCH.
//  Latency: go sampled high in IDLE at edge k -> rd=1 from k+1.
//   Burst with no ws: rd high 2*BURST_LEN cycles, then ds=1 for 1 cycle, then IDLE.
//   Minimum gap between bursts: 1 IDLE cycle after DONE.
//  Arbitration: the first set go bit at or after rr_ptr, searching upward and wrapping, wins.
//   Other requests stay pending, so requesters hold go.
//   go changes outside IDLE are ignored; go dropping mid-burst does not abort.
//  Counters: beat and wait_cnt never wrap. The FSM leaves DLY before either overflows.
//   An unused/illegal state encoding recovers to IDLE next cycle with gnt=0.
//  rd/ds/err/gnt/beat are driven only from flops; there are no combinational paths from inputs to outputs.
// STRUCTURE
//  glitchless_pkg: state enum (5-bit, encodings above) and named bit positions RD_BIT=2, DS_BIT=3, ERR_BIT=4.
//  Sub-module glitchless_rr_arb: combinational round-robin pick.
//   Inputs: req[NCH], ptr; outputs: one-hot gnt_nxt, idx_nxt.
//   The top level registers its outputs.
//  Top: state flop, next-state always_comb with unique case, beat/wait counters, rr_ptr.
// TESTING  (defaults NCH=4, BURST_LEN=4, MAX_WAIT=8 unless stated)
//  1 BURST_LEN=1, go=0001, ws=0: rd=1 for 2 cycles, ds=1 on cycle 3, gnt=0001 throughout, IDLE on cycle 4.
//  2 go=0100, ws=0: beat steps 0,0,1,1,2,2,3,3 with rd=1 (8 cycles), then ds=1 once, err never.
//  3 ws=1 for 3 DLY samples on beat 1, then 0: beat 1 re-issued 3 times, total rd cycles 14, then ds=1.
//  4 ws held 1: err=1 on the cycle after the 8th ws-in-DLY sample, ds stays 0, then IDLE with gnt=0.
//  5 go=1111 held for 5 bursts: gnt sequence 0001,0010,0100,1000,0001; one ds per burst.
//  6 reset_n=0 during DLY of beat 2: next cycle rd=ds=err=0, gnt=0, beat=0; a new go restarts at beat 0.
//  Assertions: onehot0(gnt); $onehot0({err,ds,rd}); ds/err only one cycle wide; rd==0 in IDLE.

Source files
------------

// File: rtl/glitchless_pkg.sv
// Shared types for the glitch-free burst read controller: output-encoded state and bit positions.
package glitchless_pkg;

  // {err, ds, rd, s1, s0}; rd/ds/err come straight off the state register.
  typedef enum logic [4:0] {
    StIdle = 5'b000_00,
    StRead = 5'b001_01,
    StDly  = 5'b001_10,
    StDone = 5'b010_11,
    StErr  = 5'b100_00
  } state_e;

  localparam int unsigned RD_BIT  = 2;
  localparam int unsigned DS_BIT  = 3;
  localparam int unsigned ERR_BIT = 4;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/glitchless_rr_arb.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module glitchless_rr_arb
  import glitchless_pkg::*;
#(
  parameter int unsigned NCH = 4,
  localparam int unsigned IDX_W = clog2_min1(NCH)
) (
  input  logic [NCH-1:0]   req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NCH-1:0]   gnt_nxt,
  output logic [IDX_W-1:0] idx_nxt
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] j;
    gnt_nxt = '0;
    idx_nxt = '0;
    found   = 1'b0;
    j       = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      j = IDX_W'((32'(ptr) + i) % NCH);
      if (!found && req[j]) begin
        found      = 1'b1;
        gnt_nxt[j] = 1'b1;
        idx_nxt    = j;
      end
    end
  end

endmodule

// File: rtl/glitchless_burst_rd.sv
// Round-robin burst read controller whose rd/ds/err strobes are raw state-register bits.
module glitchless_burst_rd
  import glitchless_pkg::*;
#(
  parameter int unsigned NCH       = 4,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned MAX_WAIT  = 8,
  localparam int unsigned BEAT_W   = clog2_min1(BURST_LEN),
  localparam int unsigned WAIT_W   = clog2_min1(MAX_WAIT),
  localparam int unsigned IDX_W    = clog2_min1(NCH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NCH-1:0]    go,
  input  logic              ws,
  output logic              rd,
  output logic              ds,
  output logic              err,
  output logic [NCH-1:0]    gnt,
  output logic [BEAT_W-1:0] beat
);

  state_e            state_q, state_d;
  logic [NCH-1:0]    gnt_q, gnt_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic [NCH-1:0]    arb_gnt;
  logic [IDX_W-1:0]  arb_idx;

  glitchless_rr_arb #(
    .NCH(NCH)
  ) u_arb (
    .req    (go),
    .ptr    (ptr_q),
    .gnt_nxt(arb_gnt),
    .idx_nxt(arb_idx)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (|go) begin
          state_d = StRead;
          gnt_d   = arb_gnt;
          idx_d   = arb_idx;
          beat_d  = '0;
          wait_d  = '0;
        end
      end
      StRead: state_d = StDly;
      StDly: begin
        if (!ws) begin
          if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
            state_d = StDone;
          end else begin
            state_d = StRead;
            beat_d  = beat_q + 1'b1;
            wait_d  = '0;
          end
        end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
          state_d = StErr;
        end else begin
          // Same beat is re-issued; only the wait budget is consumed.
          state_d = StRead;
          wait_d  = wait_q + 1'b1;
        end
      end
      StDone, StErr: begin
        state_d = StIdle;
        gnt_d   = '0;
        ptr_d   = (idx_q == IDX_W'(NCH - 1)) ? '0 : idx_q + 1'b1;
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    rd   = state_q[RD_BIT];
    ds   = state_q[DS_BIT];
    err  = state_q[ERR_BIT];
    gnt  = gnt_q;
    beat = beat_q;
  end

endmodule

// File: tb/tb_glitchless_burst_rd.sv
// Table-driven, scoreboarded bench for glitchless_burst_rd plus a BURST_LEN=1 instance.
module tb_glitchless_burst_rd;
  import glitchless_pkg::*;

  typedef struct {
    logic [3:0]  go;
    logic [15:0] ws;         // ws value for the n-th DLY sample of the burst
    logic [3:0]  gnt;
    int          rd_cycles;
    logic        is_err;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    int         rd_cycles;
    logic       is_err;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] go, go1;
  logic       ws, ws1;
  logic       rd, ds, err, rd1, ds1, err1;
  logic [3:0] gnt, gnt1;
  logic [1:0] beat;
  logic [0:0] beat1;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[12];
  vec_t v_after;

  always #5 clk = ~clk;

  glitchless_burst_rd #(.NCH(4), .BURST_LEN(4), .MAX_WAIT(8)) dut (
    .clk(clk), .reset_n(reset_n), .go(go), .ws(ws),
    .rd(rd), .ds(ds), .err(err), .gnt(gnt), .beat(beat)
  );

  glitchless_burst_rd #(.NCH(4), .BURST_LEN(1), .MAX_WAIT(8)) dut1 (
    .clk(clk), .reset_n(reset_n), .go(go1), .ws(ws1),
    .rd(rd1), .ds(ds1), .err(err1), .gnt(gnt1), .beat(beat1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Invariants checked on every clock outside reset.
  logic ds_prev, err_prev;
  always @(posedge clk) begin
    if (!reset_n) begin
      ds_prev  <= 1'b0;
      err_prev <= 1'b0;
    end else begin
      checks++;
      if (!$onehot0(gnt) || !$onehot0({err, ds, rd}) || (ds && ds_prev) || (err && err_prev)
          || (dut.state_q == StIdle && rd)) begin
        errors++;
        $display("FAIL invariant: got gnt=%b err/ds/rd=%b%b%b ds_prev=%b err_prev=%b",
                 gnt, err, ds, rd, ds_prev, err_prev);
      end
      ds_prev  <= ds;
      err_prev <= err;
    end
  end

  task automatic run_vec(input vec_t v);
    exp_t       e;
    int         n, rd_cnt, dly;
    logic [1:0] beat_exp;
    go = v.go;
    sb.push_back('{gnt: v.gnt, rd_cycles: v.rd_cycles, is_err: v.is_err});
    n = 0;
    do begin
      ws = 1'($urandom);
      @(negedge clk);
      n++;
    end while (!rd && n < 20);
    check("burst_start", 32'(rd), 1);
    rd_cnt = 0; dly = 0; beat_exp = '0; n = 0;
    while (rd && n < 100) begin
      rd_cnt++;
      n++;
      check("beat", 32'(beat), 32'(beat_exp));
      check("gnt_hold", 32'(gnt), 32'(v.gnt));
      if (rd_cnt % 2 == 0) begin
        // Even rd cycles are DLY: ws is only looked at here.
        ws = (dly < 16) ? v.ws[dly] : 1'b0;
        if (!ws) beat_exp++;
        dly++;
      end else begin
        ws = 1'($urandom);
      end
      @(negedge clk);
    end
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      check("rd_cycles", 32'(rd_cnt), 32'(e.rd_cycles));
      check("end_err", 32'(err), 32'(e.is_err));
      check("end_ds", 32'(ds), 32'(!e.is_err));
      check("end_gnt", 32'(gnt), 32'(e.gnt));
    end
    @(negedge clk);
    check("gap_rd", 32'(rd), 0);
    check("gap_strobes", 32'({ds, err}), 0);
    check("gap_gnt", 32'(gnt), 0);
  endtask

  initial begin
    int n, rd_cnt;
    vecs[0]  = '{4'b1111, 16'h0000, 4'b0001, 8,  1'b0};
    vecs[1]  = '{4'b1111, 16'h0000, 4'b0010, 8,  1'b0};
    vecs[2]  = '{4'b1111, 16'h0000, 4'b0100, 8,  1'b0};
    vecs[3]  = '{4'b1111, 16'h0000, 4'b1000, 8,  1'b0};
    vecs[4]  = '{4'b1111, 16'h0000, 4'b0001, 8,  1'b0};
    vecs[5]  = '{4'b0100, 16'h0000, 4'b0100, 8,  1'b0};
    vecs[6]  = '{4'b0001, 16'h000E, 4'b0001, 14, 1'b0};
    vecs[7]  = '{4'b1111, 16'hFFFF, 4'b0010, 16, 1'b1};
    vecs[8]  = '{4'b1001, 16'h0000, 4'b1000, 8,  1'b0};
    vecs[9]  = '{4'b1010, 16'h0000, 4'b0010, 8,  1'b0};
    vecs[10] = '{4'b0011, 16'h0000, 4'b0001, 8,  1'b0};
    vecs[11] = '{4'b0010, 16'h007F, 4'b0010, 22, 1'b0};
    v_after  = '{4'b0010, 16'h0000, 4'b0010, 8,  1'b0};

    reset_n = 1'b0; go = '0; go1 = '0; ws = 1'b0; ws1 = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("reset_strobes", 32'({err, ds, rd}), 0);
    check("reset_gnt", 32'(gnt), 0);
    check("reset_beat", 32'(beat), 0);

    // Single-beat burst on the BURST_LEN=1 instance.
    go1 = 4'b0001;
    n = 0;
    do begin @(negedge clk); n++; end while (!rd1 && n < 20);
    go1 = '0;
    check("bl1_c1", 32'({err1, ds1, rd1, gnt1, beat1}), 32'({3'b001, 4'b0001, 1'b0}));
    @(negedge clk);
    check("bl1_c2", 32'({err1, ds1, rd1, gnt1}), 32'({3'b001, 4'b0001}));
    @(negedge clk);
    check("bl1_c3", 32'({err1, ds1, rd1, gnt1}), 32'({3'b010, 4'b0001}));
    @(negedge clk);
    check("bl1_c4", 32'({err1, ds1, rd1, gnt1}), 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during DLY of beat 2 aborts silently; the next burst starts fresh.
    go = 4'b0100;
    n = 0;
    do begin ws = 1'b0; @(negedge clk); n++; end while (!rd && n < 20);
    rd_cnt = 1;
    while (rd_cnt < 6 && n < 40) begin
      @(negedge clk);
      rd_cnt++;
      n++;
    end
    check("mid_rd", 32'(rd), 1);
    check("mid_beat", 32'(beat), 2);
    reset_n = 1'b0;
    go = '0;
    @(negedge clk);
    check("rst_mid_strobes", 32'({err, ds, rd}), 0);
    check("rst_mid_gnt", 32'(gnt), 0);
    check("rst_mid_beat", 32'(beat), 0);
    reset_n = 1'b1;
    run_vec(v_after);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached, expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
